spi_rom_arbiter: RTL and testbench
==================================

Name: spi_rom_arbiter

Overview:
- Shares the single 32x16 synchronous ROM port between two read requesters.
  - Requester 0 is the SPI interface's memory read path, which is latency-critical.
  - Requester 1 is an auxiliary reader: a scrubber or CRC checker.
- Fixed priority to requester 0, with a starvation limit that forces a grant to requester 1.
- One transaction in flight at a time. Sits between the requesters and the ROM, in the sck domain.

Parameters:
- AW, 5: address width (32 words).
- DW, 16: data width.
- STARVE_LIM, 4: consecutive arbitrations requester 1 may lose while requesting before it is forced to win. Legal range is >=1; 0 is illegal and gets an elaboration-time assertion.

Ports:
- sck  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  2  read request per requester; level, held until granted.
- addr0_i  in  AW  requester 0 address; stable from req_i[0] rise through gnt_o[0].
- addr1_i  in  AW  requester 1 address; same stability rule as addr0_i.
- gnt_o  out  2  one-cycle grant pulse, one-hot.
- rvalid_o  out  2  one-cycle read-data-valid pulse to the owning requester.
- rdata_o  out  DW  read data, shared by both requesters and qualified by rvalid_o.
- mem_en_o  out  1  ROM read enable.
- mem_addr_o  out  AW  ROM address.
- mem_data_i  in  DW  ROM data, valid the cycle after the ROM samples mem_en_o=1.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - gnt_o, rvalid_o, mem_en_o and busy_o go to 0.
  - mem_addr_o, rdata_o, owner and starve_cnt go to 0.
  - Reset mid-transaction drops the transaction; no rvalid_o is produced for it.
- All outputs are registered or decoded from registered state.
- State machine, with states IDLE, ISSUE, WAIT and RESP:
  - IDLE: if req_i is nonzero, arbitrate, latch owner and addr into addr_q, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): gnt_o[owner]=1, mem_en_o=1, mem_addr_o=addr_q. Next state is WAIT.
  - WAIT (1 cycle): rdata_q <= mem_data_i. Next state is RESP.
  - RESP (1 cycle): rvalid_o[owner]=1 and rdata_o=rdata_q. Arbitrate exactly as in IDLE: go to ISSUE if any request is present, else go to IDLE.
- Latency and throughput:
  - req_i first seen at the end of cycle C (IDLE) gives gnt_o in C+1 and rvalid_o in C+3.
  - Back-to-back transactions run at one per 3 cycles.
- Requester obligation:
  - Deassert req_i[k] in the cycle after gnt_o[k] unless another read is wanted.
  - req_i sampled in RESP is treated as a new request.
- mem_addr_o holds addr_q outside ISSUE. rdata_o holds its last value between RESP cycles.
- Arbitration, performed in IDLE or RESP:
  - Only req_i[0] set: 0 wins; starve_cnt <= 0.
  - Only req_i[1] set: 1 wins; starve_cnt <= 0.
  - Both set and starve_cnt < STARVE_LIM: 0 wins; starve_cnt increments, saturating at STARVE_LIM.
  - Both set and starve_cnt == STARVE_LIM: 1 wins; starve_cnt <= 0.
  - req_i[1] low at an arbitration point: starve_cnt <= 0.
- starve_cnt width is $clog2(STARVE_LIM+1).
- gnt_o and rvalid_o are never asserted for both requesters in the same cycle.
- No request is lost: a held request is granted within (STARVE_LIM+1) transactions.

Decomposition:
- Package spi_rom_arb_pkg holds:
  - state_t enum (IDLE, ISSUE, WAIT, RESP).
  - ROM_AW=5 and ROM_DW=16.
  - REQ_SPI=0 and REQ_AUX=1.
- Sub-module spi_rom_arb_pick: combinational winner select plus the registered starve_cnt, with an advance enable driven at arbitration points.

Test Plan:
- Single read: req_i=01, addr0_i=5'h03, ROM word 3 = 16'hBEEF.
  - Expect gnt_o=01 at C+1 with mem_en_o=1 and mem_addr_o=03.
  - Expect rvalid_o=01 at C+3 with rdata_o=BEEF, then IDLE with busy_o=0.
- Contention: req_i=11 held continuously, STARVE_LIM=4.
  - Expect grant order 0,0,0,0,1,0,0,0,0,1, with consecutive gnt_o pulses 3 cycles apart.
- Aux only: req_i=10, addr1_i=5'h1F.
  - Expect gnt_o=10, then rvalid_o=10 with rdata_o equal to ROM word 31, and starve_cnt=0.
- Counter clear: req_i=11 for 3 transactions, then req_i[1] dropped for 1 arbitration, then req_i=11 again.
  - Expect 4 more requester-0 grants before requester 1 is granted.
- Reset mid-flight: pull rst_n low during WAIT.
  - Expect all outputs 0 immediately and no rvalid_o after release.
  - First request after release gets gnt_o one cycle after it is sampled.
- Back-to-back on requester 0: req_i[0] held with addresses 0, 1, 2.
  - Expect gnt_o[0] every 3 cycles and rvalid_o[0] data equal to ROM words 0, 1, 2 in order.
  - rdata_o holds the word 2 value afterwards.

Source files
------------

// File: rtl/spi_rom_arb_pkg.sv
// Shared types and constants for the SPI ROM port arbiter.
package spi_rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int ROM_AW = 5;
    localparam int ROM_DW = 16;

    // Requester indices into req_i / gnt_o / rvalid_o
    localparam int REQ_SPI = 0;
    localparam int REQ_AUX = 1;

endpackage

// File: rtl/spi_rom_arb_pick.sv
// Winner select between the SPI and aux requesters. SPI has fixed priority,
// but after STARVE_LIM consecutive lost arbitrations the aux side is forced in.
module spi_rom_arb_pick
    import spi_rom_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,   // high at arbitration points
    output logic       win    // 1: aux wins, 0: SPI wins
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    // A zero limit would never let the counter express "aux lost once".
    if (STARVE_LIM < 1) begin : g_lim_chk
        $error("spi_rom_arb_pick: STARVE_LIM must be >= 1");
    end

    logic [CW-1:0] starve_cnt;
    logic          at_lim;

    assign at_lim = (starve_cnt == LIM);

    // Aux wins when alone, or when contending and already starved to the limit
    always_comb begin
        win = req[REQ_AUX] & (~req[REQ_SPI] | at_lim);
    end

    // Count aux losses under contention; any other arbitration outcome clears it
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (adv) begin
            if (req[REQ_AUX] && req[REQ_SPI] && !at_lim)
                starve_cnt <= starve_cnt + CW'(1);
            else
                starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/spi_rom_arbiter.sv
// Shares the single synchronous ROM read port between the SPI read path
// and an auxiliary reader, one transaction in flight at a time.
module spi_rom_arbiter
    import spi_rom_arb_pkg::*;
#(
    parameter int AW         = ROM_AW,
    parameter int DW         = ROM_DW,
    parameter int STARVE_LIM = 4
) (
    input  logic          sck,
    input  logic          rst_n,
    input  logic [1:0]    req_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          mem_en_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          busy_o
);

    state_t        state, state_nxt;
    logic          owner;     // 1: aux owns the transaction
    logic [AW-1:0] addr_q;
    logic [DW-1:0] rdata_q;
    logic          arb_pt;
    logic          win;

    // IDLE and RESP are the only points where a new owner can be picked
    assign arb_pt = (state == IDLE) || (state == RESP);

    spi_rom_arb_pick #(
        .STARVE_LIM(STARVE_LIM)
    ) u_pick (
        .sck   (sck),
        .rst_n (rst_n),
        .req   (req_i),
        .adv   (arb_pt),
        .win   (win)
    );

    // State register
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: fixed ISSUE->WAIT->RESP walk, re-arbitrate from IDLE/RESP
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (|req_i) ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = (|req_i) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state and owner
    always_comb begin
        gnt_o    = 2'b00;
        rvalid_o = 2'b00;
        mem_en_o = 1'b0;
        busy_o   = (state != IDLE);
        case (state)
            ISSUE: begin
                gnt_o[REQ_AUX] = owner;
                gnt_o[REQ_SPI] = ~owner;
                mem_en_o       = 1'b1;
            end
            RESP: begin
                rvalid_o[REQ_AUX] = owner;
                rvalid_o[REQ_SPI] = ~owner;
            end
            default: ;
        endcase
    end

    assign mem_addr_o = addr_q;
    assign rdata_o    = rdata_q;

    // Latch owner/address on a successful arbitration, capture ROM data in WAIT
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (arb_pt && (|req_i)) begin
                owner  <= win;
                addr_q <= win ? addr1_i : addr0_i;
            end
            if (state == WAIT)
                rdata_q <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Directed bench for spi_rom_arbiter with a 32x16 synchronous ROM model.
module tb_spi_rom_arbiter;

    logic        sck = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [4:0]  addr0_i, addr1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [15:0] rdata_o;
    logic        mem_en_o;
    logic [4:0]  mem_addr_o;
    logic [15:0] mem_data_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] rom [32];

    always #5 sck = ~sck;

    spi_rom_arbiter #(.AW(5), .DW(16), .STARVE_LIM(4)) dut (
        .sck        (sck),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .addr0_i    (addr0_i),
        .addr1_i    (addr1_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .mem_en_o   (mem_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .busy_o     (busy_o)
    );

    // Synchronous ROM: data appears the cycle after an enabled read
    always @(posedge sck) begin
        if (mem_en_o) mem_data_i <= rom[mem_addr_o];
    end

    // Wait (bounded) for the next grant pulse; reports cycles waited
    task automatic wait_grant(output logic [1:0] g, output int cyc);
        g = 2'b00;
        cyc = 0;
        while (g == 2'b00 && cyc < 8) begin
            @(negedge sck);
            cyc++;
            g = gnt_o;
        end
        checks++;
        if (g == 2'b00) begin
            errors++;
            $display("FAIL grant_timeout: gnt_o=%b after %0d cycles, required a grant", g, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 2'b00; addr0_i = '0; addr1_i = '0;
        repeat (2) @(negedge sck);
        checks++;
        if ({gnt_o, rvalid_o, mem_en_o, busy_o, mem_addr_o, rdata_o} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b en=%b busy=%b addr=%h rdata=%h, required all 0",
                     gnt_o, rvalid_o, mem_en_o, busy_o, mem_addr_o, rdata_o);
        end
        rst_n = 1'b1;
        @(negedge sck);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy_o=%b, required 0", busy_o);
        end
    endtask

    task automatic test_single();
        req_i = 2'b01; addr0_i = 5'h03;
        @(negedge sck);
        checks++;
        if (gnt_o !== 2'b01 || mem_en_o !== 1'b1 || mem_addr_o !== 5'h03 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: gnt=%b en=%b addr=%h busy=%b, required 01 1 03 1",
                     gnt_o, mem_en_o, mem_addr_o, busy_o);
        end
        req_i = 2'b00;
        @(negedge sck);
        checks++;
        if (gnt_o !== 2'b00 || rvalid_o !== 2'b00 || mem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: gnt=%b rvalid=%b en=%b, required 00 00 0", gnt_o, rvalid_o, mem_en_o);
        end
        @(negedge sck);
        checks++;
        if (rvalid_o !== 2'b01 || rdata_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_resp: rvalid=%b rdata=%h, required 01 beef", rvalid_o, rdata_o);
        end
        @(negedge sck);
        checks++;
        if (busy_o !== 1'b0 || rvalid_o !== 2'b00 || rdata_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_idle: busy=%b rvalid=%b rdata=%h, required 0 00 beef", busy_o, rvalid_o, rdata_o);
        end
    endtask

    task automatic test_contention();
        logic [9:0]  exp_aux;
        logic [1:0]  g;
        logic [1:0]  exp_g;
        int          c;
        exp_aux = 10'b10_0001_0000;
        req_i = 2'b11; addr0_i = 5'h01; addr1_i = 5'h02;
        for (int i = 0; i < 10; i++) begin
            wait_grant(g, c);
            exp_g = exp_aux[i] ? 2'b10 : 2'b01;
            checks++;
            if (g !== exp_g) begin
                errors++;
                $display("FAIL contention_order[%0d]: gnt=%b, required %b", i, g, exp_g);
            end
            if (i > 0) begin
                checks++;
                if (c !== 3) begin
                    errors++;
                    $display("FAIL contention_spacing[%0d]: %0d cycles, required 3", i, c);
                end
            end
            if (i == 9) req_i = 2'b00;
        end
        repeat (3) @(negedge sck);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_aux();
        logic [1:0] g;
        int         c;
        req_i = 2'b10; addr1_i = 5'h1F;
        wait_grant(g, c);
        checks++;
        if (g !== 2'b10 || mem_addr_o !== 5'h1F) begin
            errors++;
            $display("FAIL aux_grant: gnt=%b addr=%h, required 10 1f", g, mem_addr_o);
        end
        req_i = 2'b00;
        repeat (2) @(negedge sck);
        checks++;
        if (rvalid_o !== 2'b10 || rdata_o !== 16'hA51F) begin
            errors++;
            $display("FAIL aux_resp: rvalid=%b rdata=%h, required 10 a51f", rvalid_o, rdata_o);
        end
        checks++;
        if (dut.u_pick.starve_cnt !== 3'd0) begin
            errors++;
            $display("FAIL aux_starve_cnt: starve_cnt=%0d, required 0", dut.u_pick.starve_cnt);
        end
        @(negedge sck);
    endtask

    task automatic test_counter_clear();
        logic [1:0] g;
        int         c;
        req_i = 2'b11; addr0_i = 5'h04; addr1_i = 5'h05;
        for (int i = 0; i < 3; i++) begin
            wait_grant(g, c);
            checks++;
            if (g !== 2'b01) begin
                errors++;
                $display("FAIL clear_pre[%0d]: gnt=%b, required 01", i, g);
            end
        end
        req_i = 2'b01;
        wait_grant(g, c);
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("FAIL clear_drop: gnt=%b, required 01", g);
        end
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, c);
            checks++;
            if (g !== 2'b01) begin
                errors++;
                $display("FAIL clear_post[%0d]: gnt=%b, required 01", i, g);
            end
        end
        wait_grant(g, c);
        checks++;
        if (g !== 2'b10) begin
            errors++;
            $display("FAIL clear_aux: gnt=%b, required 10", g);
        end
        req_i = 2'b00;
        repeat (3) @(negedge sck);
    endtask

    task automatic test_reset_midflight();
        logic [1:0] g;
        logic [2:0] seen;
        int         c;
        req_i = 2'b01; addr0_i = 5'h07;
        wait_grant(g, c);
        req_i = 2'b00;
        @(negedge sck);   // now in WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_o, rvalid_o, mem_en_o, busy_o, mem_addr_o, rdata_o} !== 27'd0) begin
            errors++;
            $display("FAIL midflight_reset: gnt=%b rvalid=%b en=%b busy=%b addr=%h rdata=%h, required all 0",
                     gnt_o, rvalid_o, mem_en_o, busy_o, mem_addr_o, rdata_o);
        end
        repeat (2) @(negedge sck);
        rst_n = 1'b1;
        seen = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge sck);
            seen = seen | {rvalid_o, busy_o};
        end
        checks++;
        if (seen !== 3'b000) begin
            errors++;
            $display("FAIL midflight_no_rvalid: {rvalid,busy} seen=%b, required 000", seen);
        end
        req_i = 2'b01; addr0_i = 5'h04;
        @(negedge sck);
        checks++;
        if (gnt_o !== 2'b01 || mem_addr_o !== 5'h04) begin
            errors++;
            $display("FAIL midflight_first_req: gnt=%b addr=%h, required 01 04", gnt_o, mem_addr_o);
        end
        req_i = 2'b00;
        repeat (3) @(negedge sck);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  g;
        logic [15:0] exp_d [3];
        logic [4:0]  exp_a;
        int          c;
        exp_d[0] = 16'hA500; exp_d[1] = 16'hA501; exp_d[2] = 16'hA502;
        req_i = 2'b01; addr0_i = 5'h00;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g, c);
            exp_a = 5'(k);
            checks++;
            if (g !== 2'b01 || mem_addr_o !== exp_a) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: gnt=%b addr=%h, required 01 %h", k, g, mem_addr_o, exp_a);
            end
            if (k > 0) begin
                checks++;
                if (c !== 1) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles after rvalid, required 1", k, c);
                end
            end
            if (k < 2) addr0_i = 5'(k + 1);
            else       req_i = 2'b00;
            repeat (2) @(negedge sck);
            checks++;
            if (rvalid_o !== 2'b01 || rdata_o !== exp_d[k]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: rvalid=%b rdata=%h, required 01 %h", k, rvalid_o, rdata_o, exp_d[k]);
            end
        end
        @(negedge sck);
        checks++;
        if (rdata_o !== 16'hA502 || busy_o !== 1'b0 || rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL b2b_hold: rdata=%h busy=%b rvalid=%b, required a502 0 00", rdata_o, busy_o, rvalid_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'hA500 | 16'(i);
        rom[3] = 16'hBEEF;
        test_reset();
        test_single();
        test_contention();
        test_aux();
        test_counter_clear();
        test_reset_midflight();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
